writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges the two result producers of the core, the single-cycle ALU path and the variable-latency load return path, onto the register file's single write port. Load returns are held in a small in-order queue. The ALU path has priority. The write-port outputs are registered and drive the register file's `we`/`A3`/`WD` directly. A combinational lookup lets the hazard unit stall any instruction whose destination still has a pending load write.

## Interface
Parameters:
- `DATA_WIDTH`, 32, result/write data width
- `ADDRESS_WIDTH`, 5, register index width
- `LQ_DEPTH`, 4, load-queue entries; must be a power of two, ≥2

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `res`  in  1  reset, asynchronous, active-high
- `alu_valid`  in  1  ALU result present this cycle
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  ADDRESS_WIDTH  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `lsu_valid`  in  1  load data present this cycle
- `lsu_ready`  out  1  load queue can accept
- `lsu_rd`  in  ADDRESS_WIDTH  load destination register
- `lsu_data`  in  DATA_WIDTH  load data
- `we`  out  1  register-file write enable
- `A3`  out  ADDRESS_WIDTH  register-file write address
- `WD`  out  DATA_WIDTH  register-file write data
- `chk_rd`  in  ADDRESS_WIDTH  hazard lookup register index
- `chk_hit`  out  1  a pending load write targets `chk_rd`
- `lq_count`  out  clog2(LQ_DEPTH)+1  number of occupied queue entries

## Operation
- Load channel: a transfer occurs when `lsu_valid && lsu_ready`. `lsu_ready = (lq_count != LQ_DEPTH)`; a same-cycle pop is not counted. `lsu_rd == 0` transfers are accepted and discarded, never enqueued.
- ALU channel: a transfer occurs when `alu_valid && alu_ready`. `alu_ready = 1` except in the full-priority case (see Configuration).
- Arbitration each cycle, in this order:
  1. If an ALU transfer occurs with `alu_rd != 0`, it is the winner.
  2. Otherwise, if the queue is non-empty, the queue head is the winner and is popped.
  3. Otherwise there is no winner.
- ALU transfers with `alu_rd == 0` are accepted and dropped, and do not block a queue pop.
- Output register: loads `{1, winner rd, winner data}`, or `we = 0` when there is no winner. `A3`/`WD` hold their previous values when `we = 0`.
- Queue: circular buffer with read/write pointers of `clog2(LQ_DEPTH)` bits that wrap naturally. Simultaneous push and pop is allowed at any occupancy below full, and leaves the count unchanged.
- `chk_hit`: true iff `chk_rd != 0` AND (any occupied queue entry has rd == `chk_rd`, OR (`we` && `A3 == chk_rd` && the output register holds a load)). Purely combinational.
- WAW ordering between an older queued load and a younger ALU write to the same rd is not resolved here. The hazard unit must stall on `chk_hit`.

## Timing
- Reset (async, immediate): `we = 0`, `A3 = 0`, `WD = 0`, queue empty, `lq_count = 0`, `lsu_ready = 1`, `alu_ready = 1`, `chk_hit = 0`. Queue contents are discarded, including when reset is asserted mid-drain.
- ALU latency: transfer in cycle N → `we` high in cycle N+1.
- Load latency: push in cycle N → earliest `we` in cycle N+2. The entry is visible as head in N+1.
- Write throughput: one write per cycle. Continuous ALU traffic starves the queue; the load producer sees back-pressure through `lsu_ready`.

## Configuration
- `WB_FULL_PRIORITY_EN` defined: when `lq_count == LQ_DEPTH`, `alu_ready = 0`, and the queue head wins and pops that cycle. This guarantees forward progress for loads.
- Not defined: `alu_ready` is tied to 1 and the ALU always wins.

## Structure
- The shared constants header supplies the `DATA_WIDTH`/`ADDRESS_WIDTH` defaults and the zero-register index constant.
- One sub-module, `wb_load_queue`: parametric FIFO with push/pop/count and a per-entry rd compare vector for `chk_hit`.
- Arbitration and the output register stay in the top module.

## Test plan
- Reset, then `alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF` in cycle 1 → cycle 2: `we=1`, `A3=5`, `WD=0xDEADBEEF`.
- Load `rd=7, data=0x11` pushed in cycle 1 while the ALU is idle → `we=1`, `A3=7` in cycle 3; `chk_rd=7` gives `chk_hit=1` through cycle 3 and 0 in cycle 4.
- Push 4 loads back-to-back with the ALU busy every cycle (macro off) → `lq_count=4`, `lsu_ready=0`; ALU stops → the queue drains in order over 4 cycles.
- Same as the previous test with the macro on → at `lq_count=4`, `alu_ready=0` and the head is written in the next cycle.
- `alu_rd=0` together with a non-empty queue → no ALU write; the queue head is written in the following cycle. A load with `rd=0` → not enqueued, `lq_count` unchanged.
- Assert `res` asynchronously with 3 entries queued → `we`, `lq_count` and `chk_hit` drop to 0 immediately; no writes occur after release.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter slice.
package writeback_arbiter_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH = 5;
    localparam int unsigned WB_ZERO_REG   = 0;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_ALU,
        WIN_LOAD
    } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_load_queue.sv
// In-order load-return FIFO with per-entry destination compare for hazard lookup.
module wb_load_queue
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DEPTH         = 4,
    localparam int unsigned PW           = $clog2(DEPTH),
    localparam int unsigned CW           = PW + 1
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push_i,
    input  logic [ADDRESS_WIDTH-1:0] push_rd_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     pop_i,
    output logic [ADDRESS_WIDTH-1:0] head_rd_o,
    output logic [DATA_WIDTH-1:0]    head_data_o,
    output logic [CW-1:0]            count_o,
    output logic                     full_o,
    output logic                     empty_o,
    input  logic [ADDRESS_WIDTH-1:0] chk_rd_i,
    output logic [DEPTH-1:0]         match_o
);

    logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [PW-1:0]            wptr_q, rptr_q;
    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            off;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_q[wptr_q]   <= push_rd_i;
            data_q[wptr_q] <= push_data_i;
        end
    end

    // Entry i is live when its distance from the read pointer is below the count.
    always_comb begin
        match_o = '0;
        off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - rptr_q;
            match_o[i] = ({1'b0, off} < count_q) && (rd_q[i] == chk_rd_i);
        end
    end

    assign head_rd_o   = rd_q[rptr_q];
    assign head_data_o = data_q[rptr_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load-return results onto the single register-file write port.
// Optional feature macro: WB_FULL_PRIORITY_EN (full load queue overrides ALU priority).
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned LQ_DEPTH      = 4,
    localparam int unsigned CW           = $clog2(LQ_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0]    WD,
    input  logic [ADDRESS_WIDTH-1:0] chk_rd,
    output logic                     chk_hit,
    output logic [CW-1:0]            lq_count
);

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_RD = ADDRESS_WIDTH'(WB_ZERO_REG);

    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] a3_q, a3_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic                     ld_q, ld_d;
    logic                     lq_push, lq_pop, lq_full, lq_empty;
    logic [ADDRESS_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0]    head_data;
    logic [LQ_DEPTH-1:0]      lq_match;
    wb_src_e                  win;

    wb_load_queue #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DEPTH         (LQ_DEPTH)
    ) u_lq (
        .clk         (clk),
        .res         (res),
        .push_i      (lq_push),
        .push_rd_i   (lsu_rd),
        .push_data_i (lsu_data),
        .pop_i       (lq_pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .count_o     (lq_count),
        .full_o      (lq_full),
        .empty_o     (lq_empty),
        .chk_rd_i    (chk_rd),
        .match_o     (lq_match)
    );

`ifdef WB_FULL_PRIORITY_EN
    assign alu_ready = ~lq_full;
`else
    assign alu_ready = 1'b1;
`endif

    assign lsu_ready = ~lq_full;
    // rd==0 loads complete the handshake but never occupy a slot.
    assign lq_push   = lsu_valid && lsu_ready && (lsu_rd != ZERO_RD);

    always_comb begin
        win = WIN_NONE;
        if (alu_valid && alu_ready && (alu_rd != ZERO_RD)) begin
            win = WIN_ALU;
        end else if (!lq_empty) begin
            win = WIN_LOAD;
        end
    end

    always_comb begin
        we_d   = 1'b0;
        a3_d   = a3_q;
        wd_d   = wd_q;
        ld_d   = 1'b0;
        lq_pop = 1'b0;
        unique case (win)
            WIN_ALU: begin
                we_d = 1'b1;
                a3_d = alu_rd;
                wd_d = alu_data;
            end
            WIN_LOAD: begin
                we_d   = 1'b1;
                a3_d   = head_rd;
                wd_d   = head_data;
                ld_d   = 1'b1;
                lq_pop = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            we_q <= 1'b0;
            a3_q <= '0;
            wd_q <= '0;
            ld_q <= 1'b0;
        end else begin
            we_q <= we_d;
            a3_q <= a3_d;
            wd_q <= wd_d;
            ld_q <= ld_d;
        end
    end

    assign we = we_q;
    assign A3 = a3_q;
    assign WD = wd_q;

    // A load sitting in the output register is still pending until the write lands.
    assign chk_hit = (chk_rd != ZERO_RD) &&
                     ((|lq_match) || (we_q && ld_q && (a3_q == chk_rd)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: directed steps plus random traffic against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        res;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        we;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [4:0]  chk_rd;
    logic        chk_hit;
    logic [2:0]  lq_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we, m_ld;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;

    writeback_arbiter #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (5),
        .LQ_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .res       (res),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .we        (we),
        .A3        (A3),
        .WD        (WD),
        .chk_rd    (chk_rd),
        .chk_hit   (chk_hit),
        .lq_count  (lq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_alu_ready();
`ifdef WB_FULL_PRIORITY_EN
        return mq.size() != DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic model_hit();
        if (chk_rd == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == chk_rd) return 1'b1;
        return m_we && m_ld && (m_a3 == chk_rd);
    endfunction

    task automatic check_all();
        chk("alu_ready", alu_ready, model_alu_ready());
        chk("lsu_ready", lsu_ready, mq.size() != DEPTH);
        chk("lq_count", lq_count, mq.size());
        chk("we", we, m_we);
        chk("A3", A3, m_a3);
        chk("WD", WD, m_wd);
        chk("chk_hit", chk_hit, model_hit());
    endtask

    task automatic model_step();
        logic ar, push;
        ent_t e;
        ar   = model_alu_ready();
        push = lsu_valid && (mq.size() != DEPTH) && (lsu_rd != 5'd0);
        if (alu_valid && ar && alu_rd != 5'd0) begin
            m_we = 1'b1; m_a3 = alu_rd; m_wd = alu_data; m_ld = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_a3 = e.rd; m_wd = e.data; m_ld = 1'b1;
        end else begin
            m_we = 1'b0; m_ld = 1'b0;
        end
        if (push) mq.push_back({lsu_rd, lsu_data});
    endtask

    // Inputs are driven at posedge+1; checks and model update follow at posedge+2.
    task automatic cycle();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    initial begin
        res = 1'b1;
        idle();
        chk_rd = 5'd0;
        mq.delete();
        m_we = 1'b0; m_ld = 1'b0; m_a3 = '0; m_wd = '0;
        #12;
        check_all();
        @(posedge clk); #1;
        res = 1'b0;

        // ALU write lands one cycle after transfer
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cycle();
        idle();
        chk("alu_we", we, 1'b1);
        chk("alu_A3", A3, 5'd5);
        chk("alu_WD", WD, 32'hDEADBEEF);
        cycle();

        // Load latency two cycles; hazard visible until the write lands
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11; chk_rd = 5'd7;
        cycle();
        idle();
        chk("ld_hit_c2", chk_hit, 1'b1);
        cycle();
        chk("ld_we_c3", we, 1'b1);
        chk("ld_A3_c3", A3, 5'd7);
        chk("ld_hit_c3", chk_hit, 1'b1);
        cycle();
        chk("ld_hit_c4", chk_hit, 1'b0);
        cycle();

        // Fill the queue behind continuous ALU traffic
        for (int i = 0; i < DEPTH; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hA000_0000 + i;
            lsu_valid = 1'b1; lsu_rd = 5'(20 + i); lsu_data = 32'hB000_0000 + i;
            chk_rd = 5'(20 + i);
            cycle();
        end
        lsu_valid = 1'b0;
        chk("full_count", lq_count, DEPTH);
        chk("full_lsu_ready", lsu_ready, 1'b0);
`ifdef WB_FULL_PRIORITY_EN
        chk("full_alu_ready", alu_ready, 1'b0);
`else
        chk("full_alu_ready", alu_ready, 1'b1);
`endif
        cycle();
`ifdef WB_FULL_PRIORITY_EN
        chk("prio_A3", A3, 5'd20);
`else
        chk("prio_A3", A3, 5'd6);
`endif
        idle();
        for (int i = 0; i < DEPTH + 1; i++) cycle();

        // rd==0 ALU result does not block the queue head
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        cycle();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        cycle();
        chk("rd0_alu_A3", A3, 5'd9);
        chk("rd0_alu_WD", WD, 32'h99);
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
        cycle();
        idle();
        chk("rd0_load_count", lq_count, 0);
        cycle();
        chk("rd0_load_we", we, 1'b0);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'hC0 + i;
            cycle();
        end
        idle();
        chk_rd = 5'd11;
        chk("pre_rst_count", lq_count, 3);
        #2;
        res = 1'b1;
        #1;
        chk("rst_we", we, 1'b0);
        chk("rst_count", lq_count, 0);
        chk("rst_hit", chk_hit, 1'b0);
        mq.delete();
        m_we = 1'b0; m_ld = 1'b0; m_a3 = '0; m_wd = '0;
        @(posedge clk); #3;
        res = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            lsu_valid = ($urandom_range(0, 99) < 50);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
            chk_rd    = 5'($urandom_range(0, 7));
            cycle();
        end
        idle();
        for (int i = 0; i < DEPTH + 2; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
